// File: rtl/fifo_pkg.sv
// Shared helpers for the distributed-RAM FIFO: depth legality check and
// pointer arithmetic helpers used by the top level.
package fifo_pkg;

  // True when v is a non-zero power of two; used to validate DEPTH at elaboration.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Largest pointer width the helpers are expected to handle.
  localparam int unsigned PTR_W_MAX = 32;

endpackage

// File: rtl/DistributedRAM.sv
// Dual-port distributed RAM: synchronous write on port A, asynchronous read on port B.
// Contents are never reset.
module DistributedRAM #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [WIDTH-1:0]      dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [WIDTH-1:0]      doutb
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Port A write: one entry per rising edge when enabled.
  always_ff @(posedge clk) begin
    if (wea) mem_q[addra] <= dina;
  end

  // Port B read: combinational, zero latency.
  assign doutb = mem_q[addrb];

endmodule

// File: rtl/dist_ram_fifo.sv
// First-word-fall-through FIFO on a distributed RAM.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// in_ready depends only on state (no pass-through from out_ready), and out_data
// stays stable while out_valid && !out_ready because rd_ptr does not move.
module dist_ram_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] count
);

  // Pointer: MSB is the wrap bit, low ADDR_WIDTH bits index the RAM.
  typedef logic [CNT_WIDTH-1:0] ptr_t;

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_check
    $error("dist_ram_fifo: DEPTH must be a power of two and at least 2");
  end

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic empty, full, push, pop;

  // Status flags are pure functions of the pointer state.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[CNT_WIDTH-1] != rd_ptr_q[CNT_WIDTH-1]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next pointers: flush wins over both handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  // Pointer registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A write during flush lands in RAM but is discarded with the pointers.
  DistributedRAM #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .wea   (push),
    .addra (wr_ptr_q[ADDR_WIDTH-1:0]),
    .dina  (in_data),
    .addrb (rd_ptr_q[ADDR_WIDTH-1:0]),
    .doutb (out_data)
  );

  // Occupancy never exceeds DEPTH.
  a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
    count <= ptr_t'(DEPTH));

  // No write is ever accepted while full.
  a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
    !(in_valid && in_ready && full));

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Self-checking bench for dist_ram_fifo against a queue-based reference model.
module tb_dist_ram_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q[$];

  dist_ram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Driver: called at a negedge; applies inputs for one cycle, updates the model
  // at the posedge, returns at the following negedge.
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d,
                             input logic r, input logic f);
    bit acc_push, acc_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    acc_push  = v && (exp_q.size() < DEPTH);
    acc_pop   = r && (exp_q.size() > 0);
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      if (acc_pop)  void'(exp_q.pop_front());
      if (acc_push) exp_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (count !== CW'(exp_q.size())) begin
        errors++; $display("FAIL reset_count cyc=%0d got=%0d exp=%0d", i, count, exp_q.size());
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", i, out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=1", i, in_ready);
      end
      drive_cycle(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL fill_in_ready i=%0d got=%b exp=1", i, in_ready);
      end
      drive_cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    end
    checks++;
    if (count !== CW'(DEPTH)) begin
      errors++; $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full_in_ready got=%b exp=0", in_ready);
    end
    drive_cycle(1'b1, 32'h0000_0099, 1'b0, 1'b0);
    checks++;
    if (count !== CW'(exp_q.size())) begin
      errors++; $display("FAIL fill_17th_count got=%0d exp=%0d", count, exp_q.size());
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, out_valid);
      end
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, out_data, exp_q[0]);
      end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got=%b exp=0", out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_stream_wrap();
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b0);
    for (int i = 1; i < 100; i++) begin
      checks++;
      if (count !== 5'd1) begin
        errors++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, count);
      end
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, out_data, exp_q[0]);
      end
      drive_cycle(1'b1, 32'h100 + WIDTH'(i), 1'b1, 1'b0);
    end
    checks++;
    if (out_data !== 32'h163) begin
      errors++; $display("FAIL stream_last got=%h exp=%h", out_data, 32'h163);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_empty got=%b exp=0", out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 32'h200 + WIDTH'(i), 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h2AA, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd15) begin
      errors++; $display("FAIL fullpop_count got=%0d exp=15", count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL fullpop_in_ready got=%b exp=1", in_ready);
    end
    drive_cycle(1'b1, 32'h2AA, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd16) begin
      errors++; $display("FAIL fullpop_refill got=%0d exp=16", count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++; $display("FAIL fullpop_data i=%0d got=%h exp=%h", i, out_data, exp_q[0]);
      end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h300 + WIDTH'(i), 1'b0, 1'b0);
    checks++;
    if (count !== 5'd5) begin
      errors++; $display("FAIL flush_pre_count got=%0d exp=5", count);
    end
    drive_cycle(1'b1, 32'h3FF, 1'b1, 1'b1);
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL flush_count got=%0d exp=0", count);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid);
    end
    drive_cycle(1'b1, 32'hABCD, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hABCD) begin
      errors++; $display("FAIL flush_repush got=%b/%h exp=1/%h", out_valid, out_data, 32'hABCD);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 32'h400 + WIDTH'(i), 1'b0, 1'b0);
    checks++;
    if (count !== 5'd7) begin
      errors++; $display("FAIL areset_pre_count got=%0d exp=7", count);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL areset_count got=%0d exp=0", count);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid);
    end
    test_reset();
  endtask

  task automatic test_random();
    logic v, r, f;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (count !== CW'(exp_q.size())) begin
        errors++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, exp_q.size());
      end
      checks++;
      if (in_ready !== (exp_q.size() < DEPTH)) begin
        errors++; $display("FAIL rand_in_ready i=%0d got=%b", i, in_ready);
      end
      checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rand_out_valid i=%0d got=%b", i, out_valid);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (out_data !== exp_q[0]) begin
          errors++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, out_data, exp_q[0]);
        end
      end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 40) == 0);
      drive_cycle(v, $urandom, r, f);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream_wrap();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
